// File: rtl/clock_pkg.sv
// Shared time-field widths, alarm FSM state encoding and minute arithmetic.
package clock_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2
    } state_t;

    // Add d minutes to h:m. Minutes wrap 59->0 and carry into the hour.
    // The hour wraps 23->0. Valid only for d <= 59.
    function automatic logic [HR_W+MIN_W-1:0] add_minutes(
        input logic [HR_W-1:0]  h,
        input logic [MIN_W-1:0] m,
        input logic [MIN_W-1:0] d
    );
        logic [MIN_W:0]  sum;
        logic [HR_W-1:0] h_out;
        logic [MIN_W-1:0] m_out;
        sum = {1'b0, m} + {1'b0, d};
        if (sum >= 7'd60) begin
            m_out = MIN_W'(sum - 7'd60);
            h_out = (h == 5'd23) ? 5'd0 : h + 5'd1;
        end else begin
            m_out = sum[MIN_W-1:0];
            h_out = h;
        end
        return {h_out, m_out};
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm channel: stored time and enable, and a match strobe on the second tick.
module alarm_slot
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_sel,
    input  logic [HR_W-1:0]  wr_hr,
    input  logic [MIN_W-1:0] wr_min,
    input  logic [SEC_W-1:0] wr_sec,
    input  logic             wr_on,
    input  logic             sec_tick,
    input  logic [HR_W-1:0]  hr,
    input  logic [MIN_W-1:0] min,
    input  logic [SEC_W-1:0] sec,
    output logic             hit
);

    logic [HR_W-1:0]  t_hr;
    logic [MIN_W-1:0] t_min;
    logic [SEC_W-1:0] t_sec;
    logic             enabled;

    // Alarm time and enable, rewritten whenever this channel is selected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_hr    <= '0;
            t_min   <= '0;
            t_sec   <= '0;
            enabled <= 1'b0;
        end else if (wr_sel) begin
            t_hr    <= wr_hr;
            t_min   <= wr_min;
            t_sec   <= wr_sec;
            enabled <= wr_on;
        end
    end

    // A write to this channel in the same cycle suppresses the match
    assign hit = sec_tick && enabled && !wr_sel &&
                 (hr == t_hr) && (min == t_min) && (sec == t_sec);

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm controller: per-channel triggers queue as pending bits,
// served lowest-index first by a ring/snooze FSM.
// Handshake: there is no valid/ready pair; dismiss, snooze, wr_en and sec_tick
// are single-cycle pulses that act on the rising edge at which they are high.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HR_W-1:0]     hr,
    input  logic [MIN_W-1:0]    min,
    input  logic [SEC_W-1:0]    sec,
    input  logic                sec_tick,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [HR_W-1:0]     wr_hr,
    input  logic [MIN_W-1:0]    wr_min,
    input  logic [SEC_W-1:0]    wr_sec,
    input  logic                wr_on,
    input  logic                dismiss,
    input  logic                snooze,
    output logic                alarm_flag,
    output logic [IDX_W-1:0]    ring_idx,
    output logic                snoozed,
    output logic [N_ALARMS-1:0] pending,
    output state_t              fsm_state
);

    state_t              state, state_next;
    logic [7:0]          cnt, cnt_next;
    logic [IDX_W-1:0]    idx_next, sel_idx;
    logic                sel_any;
    logic [N_ALARMS-1:0] hit, wr_mask, pend_eff, served;
    logic                load_snz, kill, snz_hit;
    logic [HR_W-1:0]     snz_hr;
    logic [MIN_W-1:0]    snz_min;
    logic [SEC_W-1:0]    snz_sec;

    genvar g;
    generate
        for (g = 0; g < N_ALARMS; g++) begin : g_slot
            alarm_slot u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_sel   (wr_mask[g]),
                .wr_hr    (wr_hr),
                .wr_min   (wr_min),
                .wr_sec   (wr_sec),
                .wr_on    (wr_on),
                .sec_tick (sec_tick),
                .hr       (hr),
                .min      (min),
                .sec      (sec),
                .hit      (hit[g])
            );
        end
    endgenerate

    // One-hot write select; a write also discards that channel's pending trigger
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            wr_mask[i] = wr_en && (wr_idx == IDX_W'(i));
        end
    end

    assign pend_eff  = pending & ~wr_mask;
    assign kill      = wr_en && !wr_on && (wr_idx == ring_idx);
    assign snz_hit   = sec_tick && (hr == snz_hr) && (min == snz_min) && (sec == snz_sec);
    assign fsm_state = state;

    // Lowest-index pending channel wins service
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (pend_eff[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end

    // Next state, ring-seconds counter and served-channel selection
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = ring_idx;
        served     = '0;
        load_snz   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    state_next = ST_RING;
                    idx_next   = sel_idx;
                    served     = N_ALARMS'(1) << sel_idx;
                end
            end
            ST_RING: begin
                if (dismiss || kill) begin
                    state_next = ST_IDLE;
                end else if (sec_tick && (cnt == 8'(RING_SECS - 1))) begin
                    state_next = ST_IDLE;
                end else if (snooze) begin
                    state_next = ST_SNZ;
                    load_snz   = 1'b1;
                end else if (sec_tick) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_SNZ: begin
                if (dismiss || kill) begin
                    state_next = ST_IDLE;
                end else if (snz_hit) begin
                    state_next = ST_RING;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != ST_RING) begin
            cnt_next = '0;
        end
    end

    // State, registered outputs, pending set/clear and snooze target
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ring_idx   <= '0;
            alarm_flag <= 1'b0;
            snoozed    <= 1'b0;
            pending    <= '0;
            snz_hr     <= '0;
            snz_min    <= '0;
            snz_sec    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ring_idx   <= idx_next;
            alarm_flag <= (state_next == ST_RING);
            snoozed    <= (state_next == ST_SNZ);
            pending    <= (pending & ~served & ~wr_mask) | hit;
            if (load_snz) begin
                {snz_hr, snz_min} <= add_minutes(hr, min, MIN_W'(SNOOZE_MIN));
                snz_sec           <= sec;
            end
        end
    end

endmodule
